dp_sequencer: RTL and testbench
===============================

Name: dp_sequencer

Overview:
- Control FSM that drives the add/sub datapath: source counters A/B, result register, add/sub mux select, result write strobe.
- Sits directly upstream of the datapath. Consumes the comparator flag a_gt_b; produces all datapath enables.
- Per element i = 0..A_DEPTH-1, the datapath computes C[i] = (A[i] > B[i mod B_DEPTH]) ? A[i] - B[j] : A[i] + B[j], where j = i mod B_DEPTH.
- Runs one full pass per start request and reports completion with a done pulse.

Parameters:
- A_DEPTH, 8, number of A elements processed per pass (2..256).
- B_DEPTH, 4, number of B entries; the B index wraps at this value (1..A_DEPTH).
- RD_LAT, 1, source memory read latency in cycles, waited in FETCH (1..4).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; returns FSM to IDLE.
- start  in  1  request a pass; sampled only in IDLE.
- a_gt_b  in  1  comparator result for current A/B operands; valid in EXEC.
- clr_a  out  1  synchronous clear of A address counter.
- clr_b  out  1  synchronous clear of B address counter.
- inc_a  out  1  increment A address counter.
- inc_b  out  1  increment B address counter.
- sel_sub  out  1  mux select: 1 = subtract result, 0 = add result.
- ld_reg  out  1  load result register.
- we_c  out  1  write result register to C memory at current A address.
- busy  out  1  high from CLR through the last STORE.
- done  out  1  single-cycle pulse at end of pass.

Behaviour:
- Reset (clk, synchronous, active-high): state = IDLE, internal idx_a = 0, idx_b = 0, every output 0. Reset overrides all other inputs, including mid-pass; no partial write is issued in the reset cycle.
- All outputs are decoded from registered state and indices. a_gt_b feeds sel_sub combinationally in EXEC only.
- States and transitions:
  - IDLE: all outputs 0. If start = 1, go to CLR; otherwise stay.
  - CLR: clr_a = 1, clr_b = 1, busy = 1. Clear idx_a, idx_b and the wait counter. Go to FETCH.
  - FETCH: busy = 1. Wait RD_LAT cycles using the wait counter. Go to EXEC on the last wait cycle.
  - EXEC: ld_reg = 1, sel_sub = a_gt_b, busy = 1. Go to STORE.
  - STORE: we_c = 1, busy = 1.
    - inc_a = 1.
    - If idx_b == B_DEPTH-1: clr_b = 1, inc_b = 0, idx_b -> 0. Otherwise inc_b = 1, idx_b + 1.
    - If idx_a == A_DEPTH-1, go to DONE. Otherwise idx_a + 1 and go to FETCH.
  - DONE: done = 1 for exactly one cycle, busy = 0. Go to IDLE.
- Timing: one element takes RD_LAT+2 cycles. Start sampled at edge k gives CLR in cycle k+1 and DONE in cycle k+2+A_DEPTH*(RD_LAT+2). Default parameters: done in cycle k+26.
- Mutual exclusion: ld_reg, we_c, clr_* and inc_* never assert together except the listed combinations. inc_b and clr_b are never both 1.
- start while busy, or in DONE: ignored, not queued. start held high continuously produces back-to-back passes with one IDLE cycle between DONE and CLR.
- a_gt_b outside EXEC: ignored.
- idx_a width is clog2(A_DEPTH); idx_b width is max(1, clog2(B_DEPTH)). No index exceeds DEPTH-1.
- Illegal or unreachable state encoding: next state IDLE, all outputs 0.

Decomposition:
- Package dp_seq_pkg holds:
  - the state enum (IDLE, CLR, FETCH, EXEC, STORE, DONE);
  - a function returning the output vector for a given state;
  - a clog2-based width constant function.
- One sub-module is natural: dp_seq_idx, holding idx_a, idx_b, the wait counter and the last-element flags. The FSM stays in dp_sequencer.

Test Plan:
1. Reset then start pulse at cycle 0, a_gt_b = 0 throughout -> clr_a/clr_b in cycle 1; 8 we_c pulses in cycles 4, 7, ..., 25, all with sel_sub = 0; done in cycle 26 only; busy high in cycles 1-25.
2. a_gt_b = 1 for even elements only -> sel_sub during EXEC follows the pattern 1,0,1,0,1,0,1,0.
3. B wrap, B_DEPTH = 4 -> clr_b in STORE of elements 3 and 7, inc_b in all other STOREs; inc_a in all 8 STOREs.
4. reset asserted during STORE of element 5 -> no we_c that cycle; all outputs 0 next cycle; a new start begins from CLR with idx_a = 0.
5. start re-pulsed while busy, and start held high -> no effect mid-pass; held high gives done, IDLE, CLR on consecutive cycles.
6. RD_LAT = 3, A_DEPTH = 2, B_DEPTH = 1 -> FETCH lasts 3 cycles; done in cycle k+12; every STORE asserts clr_b and never inc_b.

Source files
------------

// File: rtl/dp_seq_pkg.sv
// Shared types and helpers for the add/sub datapath sequencer.
package dp_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_EXEC  = 3'd3,
    S_STORE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic clr_a;
    logic clr_b;
    logic inc_a;
    logic inc_b;
    logic sel_sub;
    logic ld_reg;
    logic we_c;
    logic busy;
    logic done;
  } seq_out_t;

  // Counter width for a 0..depth-1 index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic seq_out_t decode_outputs(input state_t s, input logic b_last,
                                              input logic a_gt_b);
    seq_out_t o;
    o = '0;
    case (s)
      S_CLR: begin
        o.clr_a = 1'b1;
        o.clr_b = 1'b1;
        o.busy  = 1'b1;
      end
      S_FETCH: o.busy = 1'b1;
      S_EXEC: begin
        o.ld_reg  = 1'b1;
        o.sel_sub = a_gt_b;
        o.busy    = 1'b1;
      end
      S_STORE: begin
        o.we_c  = 1'b1;
        o.inc_a = 1'b1;
        o.clr_b = b_last;
        o.inc_b = ~b_last;
        o.busy  = 1'b1;
      end
      S_DONE:  o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dp_seq_idx.sv
// Element/B indices and read-latency wait counter for dp_sequencer.
module dp_seq_idx
  import dp_seq_pkg::*;
#(
  parameter int unsigned A_DEPTH = 8,
  parameter int unsigned B_DEPTH = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic fetch,
  input  logic store,
  output logic a_last,
  output logic b_last,
  output logic wait_last
);

  localparam int unsigned AW = idx_width(A_DEPTH);
  localparam int unsigned BW = idx_width(B_DEPTH);
  localparam int unsigned WW = idx_width(RD_LAT);
  localparam logic [AW-1:0] A_MAX = AW'(A_DEPTH - 1);
  localparam logic [BW-1:0] B_MAX = BW'(B_DEPTH - 1);
  localparam logic [WW-1:0] W_MAX = WW'(RD_LAT - 1);

  logic [AW-1:0] idx_a_q, idx_a_d;
  logic [BW-1:0] idx_b_q, idx_b_d;
  logic [WW-1:0] wait_q, wait_d;

  assign a_last    = (idx_a_q == A_MAX);
  assign b_last    = (idx_b_q == B_MAX);
  assign wait_last = (wait_q == W_MAX);

  always_comb begin
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    wait_d  = wait_q;
    if (clr) begin
      idx_a_d = '0;
      idx_b_d = '0;
      wait_d  = '0;
    end else begin
      // Wait counter rearms itself on its last cycle so each element starts from zero.
      if (fetch) wait_d = wait_last ? '0 : wait_q + WW'(1);
      if (store) begin
        idx_a_d = a_last ? idx_a_q : idx_a_q + AW'(1);
        idx_b_d = b_last ? '0 : idx_b_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_a_q <= '0;
      idx_b_q <= '0;
      wait_q  <= '0;
    end else begin
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: rtl/dp_sequencer.sv
// Control FSM for the add/sub datapath: one pass of A_DEPTH elements per start.
module dp_sequencer
  import dp_seq_pkg::*;
#(
  parameter int unsigned A_DEPTH = 8,
  parameter int unsigned B_DEPTH = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic a_gt_b,
  output logic clr_a,
  output logic clr_b,
  output logic inc_a,
  output logic inc_b,
  output logic sel_sub,
  output logic ld_reg,
  output logic we_c,
  output logic busy,
  output logic done
);

  state_t   state_q, state_d;
  seq_out_t outs;
  logic     a_last, b_last, wait_last;
  logic     in_clr, in_fetch, in_store;

  assign in_clr   = (state_q == S_CLR);
  assign in_fetch = (state_q == S_FETCH);
  assign in_store = (state_q == S_STORE);

  dp_seq_idx #(
    .A_DEPTH(A_DEPTH),
    .B_DEPTH(B_DEPTH),
    .RD_LAT (RD_LAT)
  ) u_idx (
    .clk      (clk),
    .reset    (reset),
    .clr      (in_clr),
    .fetch    (in_fetch),
    .store    (in_store),
    .a_last   (a_last),
    .b_last   (b_last),
    .wait_last(wait_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLR;
      S_CLR:   state_d = S_FETCH;
      S_FETCH: if (wait_last) state_d = S_EXEC;
      S_EXEC:  state_d = S_STORE;
      S_STORE: state_d = a_last ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Gating with reset suppresses a pending STORE write in the reset cycle itself.
  always_comb begin
    outs = '0;
    if (!reset) outs = decode_outputs(state_q, b_last, a_gt_b);
  end

  assign clr_a   = outs.clr_a;
  assign clr_b   = outs.clr_b;
  assign inc_a   = outs.inc_a;
  assign inc_b   = outs.inc_b;
  assign sel_sub = outs.sel_sub;
  assign ld_reg  = outs.ld_reg;
  assign we_c    = outs.we_c;
  assign busy    = outs.busy;
  assign done    = outs.done;

endmodule

// File: tb/tb_dp_sequencer.sv
// Bench for dp_sequencer: default instance and a RD_LAT=3/A=2/B=1 instance against a cycle-offset model.
module tb_dp_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, start = 1'b0, a_gt_b = 1'b0;

  logic u0_clr_a, u0_clr_b, u0_inc_a, u0_inc_b, u0_sel_sub, u0_ld_reg, u0_we_c, u0_busy, u0_done;
  logic u1_clr_a, u1_clr_b, u1_inc_a, u1_inc_b, u1_sel_sub, u1_ld_reg, u1_we_c, u1_busy, u1_done;

  dp_sequencer u0 (
    .clk(clk), .reset(reset), .start(start), .a_gt_b(a_gt_b),
    .clr_a(u0_clr_a), .clr_b(u0_clr_b), .inc_a(u0_inc_a), .inc_b(u0_inc_b),
    .sel_sub(u0_sel_sub), .ld_reg(u0_ld_reg), .we_c(u0_we_c), .busy(u0_busy), .done(u0_done)
  );

  dp_sequencer #(.A_DEPTH(2), .B_DEPTH(1), .RD_LAT(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .a_gt_b(a_gt_b),
    .clr_a(u1_clr_a), .clr_b(u1_clr_b), .inc_a(u1_inc_a), .inc_b(u1_inc_b),
    .sel_sub(u1_sel_sub), .ld_reg(u1_ld_reg), .we_c(u1_we_c), .busy(u1_busy), .done(u1_done)
  );

  logic [8:0] o0, o1;
  assign o0 = {u0_clr_a, u0_clr_b, u0_inc_a, u0_inc_b, u0_sel_sub, u0_ld_reg, u0_we_c, u0_busy, u0_done};
  assign o1 = {u1_clr_a, u1_clr_b, u1_inc_a, u1_inc_b, u1_sel_sub, u1_ld_reg, u1_we_c, u1_busy, u1_done};

  int checks = 0, failures = 0;
  int m_t0 = -1, m_t1 = -1;       // cycles since CLR, -1 when idle
  int we0 = 0, len0 = 0, we1 = 0, len1 = 0;

  // Expected outputs from the pass offset t: CLR at 0, then elements of (L+2) cycles, then DONE.
  function automatic logic [8:0] exp_out(int t, int l, int a, int b, logic rst, logic agb);
    int e, p;
    logic [8:0] v;
    v = '0;
    if (rst || t < 0) return v;
    if (t == 0) return 9'b110000010;
    if (t == 1 + a * (l + 2)) return 9'b000000001;
    e = (t - 1) / (l + 2);
    p = (t - 1) % (l + 2);
    if (p < l) v = 9'b000000010;
    else if (p == l) v = {4'b0000, agb, 4'b1010};
    else v = {1'b0, (e % b == b - 1), 1'b1, (e % b != b - 1), 5'b00110};
    return v;
  endfunction

  function automatic int next_t(int t, int l, int a, logic rst, logic st);
    if (rst) return -1;
    if (t < 0) return st ? 0 : -1;
    if (t == 1 + a * (l + 2)) return -1;
    return t + 1;
  endfunction

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (t0=%0d t1=%0d)", tag, obs, expv, m_t0, m_t1);
    end
  endtask

  task automatic chk_int(string tag, int obs, int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // mode 0: a_gt_b always 0; mode 1: 1 in EXEC of even elements of u0; mode 2: random.
  task automatic cycle(logic rst, logic st, int mode);
    logic agb;
    agb = 1'($urandom_range(0, 1));
    if (mode == 0) agb = 1'b0;
    else if (mode == 1 && m_t0 > 0 && m_t0 < 25 && (m_t0 - 1) % 3 == 1)
      agb = (((m_t0 - 1) / 3) % 2 == 0);
    reset = rst; start = st; a_gt_b = agb;
    #2;
    chk("u0_outputs", o0, exp_out(m_t0, 1, 8, 4, rst, agb));
    chk("u1_outputs", o1, exp_out(m_t1, 3, 2, 1, rst, agb));
    if (u0_clr_a) begin we0 = 0; len0 = 0; end else len0++;
    if (u0_we_c) we0++;
    if (u0_done) begin
      chk_int("u0_writes_per_pass", we0, 8);
      chk_int("u0_clr_to_done", len0, 25);
    end
    if (u1_clr_a) begin we1 = 0; len1 = 0; end else len1++;
    if (u1_we_c) we1++;
    if (u1_done) begin
      chk_int("u1_writes_per_pass", we1, 2);
      chk_int("u1_clr_to_done", len1, 11);
    end
    @(posedge clk);
    m_t0 = next_t(m_t0, 1, 8, rst, st);
    m_t1 = next_t(m_t1, 3, 2, rst, st);
    #1;
  endtask

  initial begin
    cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b0, 0);
    // Single pass, a_gt_b low throughout
    cycle(1'b0, 1'b1, 0);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 0);
    // Alternating comparator result per element
    cycle(1'b0, 1'b1, 1);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1);
    // Reset during STORE of element 5
    cycle(1'b0, 1'b1, 2);
    for (int i = 0; i < 40 && m_t0 != 18; i++) cycle(1'b0, 1'b0, 2);
    chk_int("reached_store5", m_t0, 18);
    cycle(1'b1, 1'b0, 2);
    cycle(1'b0, 1'b0, 2);
    cycle(1'b0, 1'b1, 2);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 2);
    // start re-pulsed mid-pass, then held high
    cycle(1'b0, 1'b1, 2);
    for (int i = 0; i < 30; i++) cycle(1'b0, (i % 7 == 3), 2);
    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b1, 2);
    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
